// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
//   Shared constants and the hex -> seven-segment decode function used by the
//   scan driver and its decoder sub-module.
//   Segment vectors are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
// -----------------------------------------------------------------------------
package sseg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Nibble to active-low segment pattern; lower-case b and d keep them
  // distinguishable from 8 and 0.
  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// -----------------------------------------------------------------------------
// hex_to_sseg
//   Combinational nibble -> seven-segment decoder.
//   Ports:
//     nibble  in  4  hex digit to display
//     seg     out 7  active-low cathodes {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
//   Drives an 8-digit multiplexed seven-segment display from a 32-bit word.
//   One digit is scanned per refresh slot of REFRESH_DIV clocks. The word is
//   snapshotted once per frame (when the scan wraps from digit 7 to digit 0)
//   so a single frame never mixes two values. Leading zeros can be blanked.
//   The empty flag lights digit 0's decimal point, full lights digit 7's.
//   Ports:
//     clk          in   1   system clock
//     rst          in   1   asynchronous active-high reset
//     value        in   32  display word, nibble i -> digit i (digit 0 rightmost)
//     empty        in   1   memory empty flag (dp of digit 0)
//     full         in   1   memory full flag (dp of digit 7)
//     enable       in   1   1 = display lit, 0 = dark while scan keeps running
//     an           out  8   anode selects, active-low
//     seg          out  7   cathodes {g,f,e,d,c,b,a}, active-low
//     dp           out  1   decimal point, active-low
//     frame_start  out  1   one-cycle pulse when a new snapshot is taken
// -----------------------------------------------------------------------------
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           value,
  input  logic                  empty,
  input  logic                  full,
  input  logic                  enable,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler_r;
  logic                    tick_s;
  logic [2:0]              idx_r;
  logic [31:0]             snap_r;

  logic [31:0]             upper_s;
  logic [3:0]              nibble_s;
  logic [6:0]              dec_seg_s;
  logic                    blank_s;
  logic                    dp_lit_s;
  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic                    dp_s;

  assign tick_s = (prescaler_r == PRESC_LAST);

  // Refresh prescaler: free-running 0..REFRESH_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_r <= '0;
    end else if (tick_s) begin
      prescaler_r <= '0;
    end else begin
      prescaler_r <= prescaler_r + PW'(1);
    end
  end

  // Digit index, per-frame snapshot and frame_start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= 3'd0;
      snap_r      <= 32'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick_s && (idx_r == IDX_LAST);
      if (tick_s) begin
        idx_r <= idx_r + 3'd1;
        if (idx_r == IDX_LAST) begin
          snap_r <= value;
        end else begin
          snap_r <= snap_r;
        end
      end else begin
        idx_r  <= idx_r;
        snap_r <= snap_r;
      end
    end
  end

  // upper_s holds snap[31:4*idx]; its low nibble is the current digit and
  // it being zero means every digit from idx upward is a leading zero.
  assign upper_s  = snap_r >> {idx_r, 2'b00};
  assign nibble_s = upper_s[3:0];

  hex_to_sseg u_dec (
    .nibble (nibble_s),
    .seg    (dec_seg_s)
  );

  // Next-cycle anode/segment/dp pattern for the current slot
  always_comb begin
    blank_s  = BLANK_LZ && (idx_r != 3'd0) && (upper_s == 32'd0);
    dp_lit_s = ((idx_r == 3'd0) && empty) || ((idx_r == IDX_LAST) && full);
    an_s     = AN_OFF;
    seg_s    = SEG_BLANK;
    dp_s     = 1'b1;
    if (enable) begin
      // A blank digit keeps its anode on only to show a lit decimal point.
      if (blank_s && !dp_lit_s) begin
        an_s = AN_OFF;
      end else begin
        an_s = ~(NUM_DIGITS'(1) << idx_r);
      end
      if (blank_s) begin
        seg_s = SEG_BLANK;
      end else begin
        seg_s = dec_seg_s;
      end
      dp_s = ~dp_lit_s;
    end else begin
      an_s  = AN_OFF;
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
    end
  end

  // Output registers; reset forces the display dark asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_s;
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
//   Self-checking bench for sseg_scan_driver with REFRESH_DIV=4. A reference
//   model derives the expected display from the number of clock edges since
//   reset release (slot = edges/4 mod 8, snapshot every 32 edges) and checks
//   every output after every edge. Directed checks cover async reset and the
//   frame_start period.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic        empty;
  logic        full;
  logic        enable;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  sseg_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .empty       (empty),
    .full        (full),
    .enable      (enable),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Segment table written straight from the digit glyph list
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  // Reference model: expected outputs after every clock edge
  int          mdl_cnt;
  logic [31:0] mdl_snap;
  initial begin
    int          d;
    logic        blank, dpl;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;
    mdl_cnt  = 0;
    mdl_snap = 32'd0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mdl_cnt  = 0;
        mdl_snap = 32'd0;
      end else begin
        d     = (mdl_cnt / 4) % 8;
        blank = (d != 0) && ((mdl_snap >> (4 * d)) == 32'd0);
        dpl   = (d == 0 && empty) || (d == 7 && full);
        if (!enable) begin
          e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          e_seg = blank ? 7'h7F : seg_tab[(mdl_snap >> (4 * d)) & 32'hF];
          e_an  = (blank && !dpl) ? 8'hFF : ~(8'd1 << d);
          e_dp  = !dpl;
        end
        mdl_cnt++;
        e_fs = (mdl_cnt % 32 == 0);
        if (e_fs) mdl_snap = value;
        #1;
        if (!rst) begin
          check_eq("an", {24'd0, an}, {24'd0, e_an});
          check_eq("seg", {25'd0, seg}, {25'd0, e_seg});
          check_eq("dp", {31'd0, dp}, {31'd0, e_dp});
          check_eq("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
        end
      end
    end
  end

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Count edges from reset release to the first frame_start (bounded)
  task automatic measure_first_frame(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #2;
      n++;
      if (frame_start) seen = 1'b1;
    end
    check_eq(tag, n, seen ? 32'd32 : 32'd32 + 32'd1000);
  endtask

  initial begin
    rst = 1'b1; value = 32'd0; empty = 1'b0; full = 1'b0; enable = 1'b1;
    run_cycles(3);
    check_eq("reset_an", {24'd0, an}, 32'h000000FF);
    check_eq("reset_seg", {25'd0, seg}, 32'h0000007F);
    check_eq("reset_dp", {31'd0, dp}, 32'd1);
    check_eq("reset_fs", {31'd0, frame_start}, 32'd0);
    rst = 1'b0;
    measure_first_frame("first_frame_latency");

    // Leading-zero blanking of F0F0
    @(negedge clk); value = 32'h0000F0F0;
    run_cycles(64);
    // Zero word with empty flag
    value = 32'd0; empty = 1'b1;
    run_cycles(64);
    empty = 1'b0;
    // Mid-frame change must not disturb the running frame
    value = 32'h0000F0F0;
    run_cycles(48);
    value = 32'h0000E3E3;
    run_cycles(48);
    // Value 1 with full: digit 7 shows only its dp
    value = 32'd1; full = 1'b1;
    run_cycles(64);
    full = 1'b0; empty = 1'b1;
    // Both flags together
    full = 1'b1;
    run_cycles(32);
    full = 1'b0; empty = 1'b0;
    // Display disabled for two frames, then resumed mid-frame
    enable = 1'b0;
    run_cycles(70);
    enable = 1'b1;
    run_cycles(30);

    // Async reset mid-scan: outputs dark before any clock edge
    @(negedge clk); value = 32'h12345678;
    run_cycles(10);
    #1 rst = 1'b1;
    #1;
    check_eq("async_an", {24'd0, an}, 32'h000000FF);
    check_eq("async_seg", {25'd0, seg}, 32'h0000007F);
    check_eq("async_dp", {31'd0, dp}, 32'd1);
    run_cycles(3);
    rst = 1'b0;
    measure_first_frame("restart_frame_latency");

    // Randomized phase: values with random leading zeros, flags toggling
    for (int f = 0; f < 16; f++) begin
      @(negedge clk);
      value = $urandom >> (4 * $urandom_range(0, 8));
      for (int c = 0; c < 32; c++) begin
        if ($urandom_range(0, 15) == 0) value = $urandom >> (4 * $urandom_range(0, 8));
        if ($urandom_range(0, 7) == 0)  empty = ~empty;
        if ($urandom_range(0, 7) == 0)  full = ~full;
        if ($urandom_range(0, 15) == 0) enable = ~enable;
        @(negedge clk);
      end
    end
    enable = 1'b1;
    run_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
